// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared constants and types for the memory-port arbiter.
//   OWNER_CPU / OWNER_DMA : encoding of the grant owner bit
//   arb_state_t           : arbiter FSM states (2-bit)
//   WAIT_CW               : width of the wait-state counter (WAIT_CYCLES 0..15)
// Optional build macro affecting users of this package: MEM_ARB_CPU_PRIO_EN.
package mem_arbiter_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  localparam int WAIT_CW = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// arb_rr_select
// Combinational grant selection between the CPU and DMA requesters.
// Ports:
//   cpu_req, dma_req : pending requests
//   last_owner       : owner of the most recently completed transaction
//   grant_valid      : at least one request is pending
//   grant_owner      : winning requester (OWNER_CPU / OWNER_DMA)
// Build macro MEM_ARB_CPU_PRIO_EN: when defined the CPU wins every tie and
// last_owner is ignored; when undefined ties alternate round-robin.
module arb_rr_select
  import mem_arbiter_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

`ifdef MEM_ARB_CPU_PRIO_EN
  // Fixed priority has no use for history; keep the input visibly consumed.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  // A single requester always wins; a tie is resolved by priority or by
  // handing the port to whoever did not have it last.
  always_comb begin
    grant_valid = cpu_req | dma_req;
    grant_owner = OWNER_CPU;
    if (cpu_req && dma_req) begin
`ifdef MEM_ARB_CPU_PRIO_EN
      grant_owner = OWNER_CPU;
`else
      grant_owner = (last_owner == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
`endif
    end else if (dma_req) begin
      grant_owner = OWNER_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between CPU and DMA requesters. A grant latches the
// winner's we/addr/wdata, drives the memory for WAIT_CYCLES+1 cycles, then
// pulses a one-cycle ack to the owner with read data registered.
// Ports:
//   clk, rst                        : clock, async active-low reset
//   cpu_req/we/addr/wdata           : CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack              : CPU read data and completion pulse
//   dma_req/we/addr/wdata           : DMA request (held until dma_ack)
//   dma_rdata, dma_ack              : DMA read data and completion pulse
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata            : memory port
//   busy                            : transaction in progress
//   owner                           : current/last grant (0 CPU, 1 DMA)
// Build macro MEM_ARB_CPU_PRIO_EN selects fixed CPU priority (see arb_rr_select).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [WAIT_CW-1:0] wait_cnt;
  logic               owner_q;
  logic               last_owner;
  logic               lat_we;
  logic [AW-1:0]      lat_addr;
  logic [DW-1:0]      lat_wdata;
  logic [DW-1:0]      cpu_rdata_q;
  logic [DW-1:0]      dma_rdata_q;
  logic               grant_valid;
  logic               grant_owner;
  logic               load;
  logic               capture;
  logic               finish;

  arb_rr_select u_select (
    .cpu_req     (cpu_req),
    .dma_req     (dma_req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // State register; reset aborts any transaction and drops mem_en/ack at once
  // because those strobes are decoded directly from this register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode. ACCESS holds until the wait counter has
  // run out; RESP is always a single cycle carrying the owner's ack.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (grant_valid) begin
          load      = 1'b1;
          state_nxt = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        mem_en = 1'b1;
        mem_we = lat_we;
        if (wait_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        finish    = 1'b1;
        cpu_ack   = (owner_q == OWNER_CPU);
        dma_ack   = (owner_q == OWNER_DMA);
        state_nxt = ARB_IDLE;
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Transaction registers. Requester inputs are only looked at on the grant,
  // so later changes on the request side cannot disturb the memory port.
  // last_owner starts at DMA so the first tie goes to the CPU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      owner_q     <= OWNER_CPU;
      last_owner  <= OWNER_DMA;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (load) begin
        owner_q  <= grant_owner;
        wait_cnt <= WAIT_CW'(WAIT_CYCLES);
        if (grant_owner == OWNER_DMA) begin
          lat_we    <= dma_we;
          lat_addr  <= dma_addr;
          lat_wdata <= dma_wdata;
        end else begin
          lat_we    <= cpu_we;
          lat_addr  <= cpu_addr;
          lat_wdata <= cpu_wdata;
        end
      end else if ((state == ARB_ACCESS) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (capture && !lat_we) begin
        if (owner_q == OWNER_DMA) begin
          dma_rdata_q <= mem_rdata;
        end else begin
          cpu_rdata_q <= mem_rdata;
        end
      end
      if (finish) begin
        last_owner <= owner_q;
      end
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state != ARB_IDLE);
  assign owner     = owner_q;

endmodule
